// File: rtl/red_pitaya_asg_interp_ch_if.sv
// Table write bus into one ASG channel.
// Driven by the parent register block.
interface red_pitaya_asg_interp_ch_if #(
  parameter int DW  = 14,
  parameter int RSZ = 14
);
  logic           buf_we_i;
  logic [RSZ-1:0] buf_addr_i;
  logic [DW-1:0]  buf_wdata_i;

  modport master (
    output buf_we_i,
    output buf_addr_i,
    output buf_wdata_i
  );

  modport slave (
    input buf_we_i,
    input buf_addr_i,
    input buf_wdata_i
  );
endinterface

// File: rtl/red_pitaya_asg_interp_ch.sv
// One ASG channel: table RAM, burst FSM,
// optional interpolation, gain/offset, saturation.
module red_pitaya_asg_interp_ch #(
  parameter int DW         = 14,
  parameter int RSZ        = 14,
  parameter int FRAC       = 16,
  parameter int CYCLE_BITS = 32,
  parameter int REP_BITS   = 16
) (
  input  logic                  dac_clk_i,
  input  logic                  dac_rst_i,
  input  logic                  trig_i,
  red_pitaya_asg_interp_ch_if.slave buf_if,
  input  logic [RSZ+FRAC-1:0]   set_size_i,
  input  logic [RSZ+FRAC-1:0]   set_step_i,
  input  logic [RSZ+FRAC-1:0]   set_ofs_i,
  input  logic                  set_rst_i,
  input  logic                  set_wrap_i,
  input  logic                  set_interp_i,
  input  logic [DW-1:0]         set_amp_i,
  input  logic [DW-1:0]         set_dc_i,
  input  logic                  set_zero_i,
  input  logic [CYCLE_BITS-1:0] set_ncyc_i,
  input  logic [REP_BITS-1:0]   set_rnum_i,
  input  logic [31:0]           set_rdly_i,
  output logic [DW-1:0]         dac_o,
  output logic [RSZ-1:0]        buf_rpnt_o,
  output logic                  busy_o,
  output logic                  trig_done_o
);
  localparam int PW = RSZ + FRAC;
  localparam logic signed [DW+1:0] SMAX =
    (DW+2)'(2**(DW-1)-1);
  localparam logic signed [DW+1:0] SMIN = ~SMAX;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DELAY
  } state_t;

  state_t                r_state;
  logic [PW-1:0]         r_pnt;
  logic [CYCLE_BITS-1:0] r_cyc;
  logic [REP_BITS-1:0]   r_rep;
  logic [31:0]           r_dly;

  logic [PW:0]   w_nxt;
  logic [PW:0]   w_rem;
  logic          w_wrap;
  logic [PW-1:0] w_wpnt;

  assign w_nxt  = {1'b0, r_pnt} + {1'b0, set_step_i};
  assign w_wrap = w_nxt > {1'b0, set_size_i};
  assign w_rem  = w_nxt - {1'b0, set_size_i}
                - (PW+1)'(1);
  assign w_wpnt = set_wrap_i ? w_rem[PW-1:0]
                             : set_ofs_i;

  // Burst sequencing and read pointer advance
  always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
    if (dac_rst_i) begin
      r_state     <= IDLE;
      r_pnt       <= '0;
      r_cyc       <= '0;
      r_rep       <= '0;
      r_dly       <= '0;
      busy_o      <= 1'b0;
      trig_done_o <= 1'b0;
    end else begin
      trig_done_o <= 1'b0;
      if (set_rst_i) begin
        r_state <= IDLE;
        r_pnt   <= set_ofs_i;
        busy_o  <= 1'b0;
      end else begin
        unique case (r_state)
          IDLE: begin
            r_pnt <= set_ofs_i;
            if (trig_i) begin
              r_state     <= RUN;
              r_cyc       <= set_ncyc_i;
              r_rep       <= set_rnum_i;
              busy_o      <= 1'b1;
              trig_done_o <= 1'b1;
            end
          end
          RUN: begin
            if (w_wrap) begin
              r_pnt       <= w_wpnt;
              trig_done_o <= 1'b1;
              if (r_cyc == CYCLE_BITS'(1)) begin
                if (r_rep != '0) begin
                  r_state <= DELAY;
                  r_rep   <= r_rep - REP_BITS'(1);
                  r_dly   <= set_rdly_i;
                end else begin
                  r_state <= IDLE;
                  busy_o  <= 1'b0;
                end
              end else if (r_cyc != '0) begin
                r_cyc <= r_cyc - CYCLE_BITS'(1);
              end
            end else begin
              r_pnt <= w_nxt[PW-1:0];
            end
          end
          DELAY: begin
            if (r_dly == '0) begin
              r_state     <= RUN;
              r_pnt       <= set_ofs_i;
              r_cyc       <= set_ncyc_i;
              trig_done_o <= 1'b1;
            end else begin
              r_dly <= r_dly - 32'd1;
            end
          end
          default: begin
            r_state <= IDLE;
            busy_o  <= 1'b0;
          end
        endcase
      end
    end
  end

  logic [RSZ-1:0] w_idx;
  logic [RSZ-1:0] w_bidx;
  logic [7:0]     w_f;

  assign w_idx  = r_pnt[PW-1:FRAC];
  assign w_f    = r_pnt[FRAC-1:FRAC-8];
  assign w_bidx =
    (w_idx == set_size_i[PW-1:FRAC])
      ? set_ofs_i[PW-1:FRAC]
      : w_idx + RSZ'(1);

  logic [DW-1:0] r_mem_a [2**RSZ];
  logic [DW-1:0] r_mem_b [2**RSZ];
  logic [RSZ-1:0] r_aa;
  logic [RSZ-1:0] r_ba;
  logic [DW-1:0]  r_a2;
  logic [DW-1:0]  r_b2;

  // Duplicated table: both copies written, one read port each
  always_ff @(posedge dac_clk_i) begin
    if (buf_if.buf_we_i) begin
      r_mem_a[buf_if.buf_addr_i] <= buf_if.buf_wdata_i;
      r_mem_b[buf_if.buf_addr_i] <= buf_if.buf_wdata_i;
    end
    r_a2 <= r_mem_a[r_aa];
    r_b2 <= r_mem_b[r_ba];
  end

  logic [7:0]           r_f1;
  logic [7:0]           r_f2;
  logic [DW-1:0]        r_a3;
  logic [DW-1:0]        r_m3;
  logic [DW-1:0]        r_s4;
  logic [DW:0]          r_g5;
  logic signed [DW:0]   w_diff;
  logic signed [DW+9:0] w_mul;
  logic signed [2*DW:0] w_p;
  logic signed [DW+1:0] w_sum;
  logic [DW-1:0]        w_sat;

  assign w_diff = signed'({r_b2[DW-1], r_b2})
                - signed'({r_a2[DW-1], r_a2});
  assign w_mul  = w_diff * signed'({1'b0, r_f2});
  assign w_p    = signed'(r_s4)
                * signed'({1'b0, set_amp_i});
  assign w_sum  = signed'({r_g5[DW], r_g5})
                + signed'({{2{set_dc_i[DW-1]}}, set_dc_i});

  // Clamp the offset result to the DAC range
  always_comb begin
    w_sat = w_sum[DW-1:0];
    if (w_sum > SMAX) begin
      w_sat = SMAX[DW-1:0];
    end else if (w_sum < SMIN) begin
      w_sat = SMIN[DW-1:0];
    end
  end

  // Six-stage read/interp/gain pipeline from pnt to dac_o
  always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
    if (dac_rst_i) begin
      r_aa       <= '0;
      r_ba       <= '0;
      r_f1       <= '0;
      r_f2       <= '0;
      r_a3       <= '0;
      r_m3       <= '0;
      r_s4       <= '0;
      r_g5       <= '0;
      buf_rpnt_o <= '0;
      dac_o      <= '0;
    end else begin
      r_aa       <= w_idx;
      r_ba       <= w_bidx;
      r_f1       <= w_f;
      buf_rpnt_o <= w_idx;
      r_f2       <= r_f1;
      r_a3       <= r_a2;
      r_m3       <= set_interp_i ? w_mul[DW+7:8] : '0;
      r_s4       <= r_a3 + r_m3;
      r_g5       <= w_p[2*DW-1:DW-1];
      dac_o      <= set_zero_i ? '0 : w_sat;
    end
  end

  logic w_unused;
  assign w_unused = ^{w_rem[PW], w_mul[DW+9:DW+8],
                      w_mul[7:0], w_p[2*DW],
                      w_p[DW-2:0]};
endmodule

// File: tb/tb_red_pitaya_asg_interp_ch.sv
// Randomized bench for one ASG channel against a
// burst timeline model and an arithmetic output model.
module tb_red_pitaya_asg_interp_ch;
  localparam int DW = 14;
  localparam int RSZ = 14;
  localparam int PW = 30;

  logic clk = 0;
  logic rst = 1;
  logic trig = 0;
  logic srst = 0;
  logic wrap = 1;
  logic interp = 0;
  logic zero = 0;
  logic [PW-1:0] size = 0;
  logic [PW-1:0] step = 0;
  logic [PW-1:0] ofs = 0;
  logic [13:0] amp = 14'h2000;
  logic [13:0] dc = 0;
  logic [31:0] ncyc = 0;
  logic [15:0] rnum = 0;
  logic [31:0] rdly = 0;
  logic [13:0] dac;
  logic [13:0] rpnt;
  logic busy;
  logic td;

  int n_chk = 0;
  int n_fail = 0;
  int mem_m [0:16383];
  bit q_busy [$];
  bit q_td [$];
  longint q_pnt [$];
  int q_obs [$];

  red_pitaya_asg_interp_ch_if #(.DW(DW), .RSZ(RSZ)) bif ();

  red_pitaya_asg_interp_ch dut (
    .dac_clk_i    (clk),
    .dac_rst_i    (rst),
    .trig_i       (trig),
    .buf_if       (bif),
    .set_size_i   (size),
    .set_step_i   (step),
    .set_ofs_i    (ofs),
    .set_rst_i    (srst),
    .set_wrap_i   (wrap),
    .set_interp_i (interp),
    .set_amp_i    (amp),
    .set_dc_i     (dc),
    .set_zero_i   (zero),
    .set_ncyc_i   (ncyc),
    .set_rnum_i   (rnum),
    .set_rdly_i   (rdly),
    .dac_o        (dac),
    .buf_rpnt_o   (rpnt),
    .busy_o       (busy),
    .trig_done_o  (td)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sx(int v);
    int r;
    r = v & 'h3FFF;
    if (r >= 8192) r = r - 16384;
    return r;
  endfunction

  task automatic wr(input int a, input int d);
    bif.buf_we_i    = 1'b1;
    bif.buf_addr_i  = a[13:0];
    bif.buf_wdata_i = d[13:0];
    tick();
    bif.buf_we_i = 1'b0;
    mem_m[a] = sx(d);
  endtask

  function automatic int idx_of(longint p);
    return int'((p >> 16) & 'h3FFF);
  endfunction

  // Expected DAC code for a given pointer value
  function automatic int model_out(longint p);
    int i, f, si, oi, a, b, s, g, o;
    i  = idx_of(p);
    f  = int'((p >> 8) & 'hFF);
    si = idx_of(longint'(size));
    oi = idx_of(longint'(ofs));
    a  = mem_m[i];
    b  = mem_m[(i == si) ? oi : (i + 1) % 16384];
    s  = interp ? a + (((b - a) * f) >>> 8) : a;
    g  = (s * int'(amp)) >>> 13;
    o  = g + sx(int'(dc));
    if (o > 8191) o = 8191;
    if (o < -8192) o = -8192;
    return o & 'h3FFF;
  endfunction

  task automatic push(input bit b, input bit t,
                      input longint p);
    q_busy.push_back(b);
    q_td.push_back(t);
    q_pnt.push_back(p);
  endtask

  // Per-clock busy/pulse/pointer timeline after a trigger
  task automatic build();
    longint p, nxt, sz, st, of;
    int w;
    bit done;
    sz = longint'(size);
    st = longint'(step);
    of = longint'(ofs);
    q_busy.delete();
    q_td.delete();
    q_pnt.delete();
    p = of;
    push(1, 1, p);
    for (int b = 0; b <= int'(rnum); b++) begin
      w = 0;
      done = 0;
      while (!done) begin
        nxt = p + st;
        if (nxt > sz) begin
          p = wrap ? nxt - sz - 1 : of;
          w++;
          if (w == int'(ncyc)) begin
            done = 1;
            if (b < int'(rnum)) begin
              push(1, 1, p);
              repeat (rdly) push(1, 0, p);
              p = of;
              push(1, 1, p);
            end else begin
              push(0, 1, p);
            end
          end else begin
            push(1, 1, p);
          end
        end else begin
          p = nxt;
          push(1, 0, p);
        end
        if (q_busy.size() > 20000) begin
          done = 1;
          b = int'(rnum);
        end
      end
    end
    repeat (8) push(0, 0, of);
  endtask

  task automatic run_burst(input string nm,
                           output int nbusy,
                           output int ntd);
    int ed, er;
    longint of;
    build();
    of = longint'(ofs);
    nbusy = 0;
    ntd = 0;
    q_obs.delete();
    repeat (8) tick();
    trig = 1;
    tick();
    trig = 0;
    for (int k = 0; k < q_busy.size(); k++) begin
      nbusy += int'(busy);
      ntd += int'(td);
      q_obs.push_back(int'(dac));
      n_chk++;
      if (busy !== q_busy[k]) begin
        n_fail++;
        $display("FAIL %s busy cyc %0d got %0b exp %0b",
                 nm, k, busy, q_busy[k]);
      end
      n_chk++;
      if (td !== q_td[k]) begin
        n_fail++;
        $display("FAIL %s trig_done cyc %0d got %0b exp %0b",
                 nm, k, td, q_td[k]);
      end
      ed = model_out(k >= 6 ? q_pnt[k-6] : of);
      n_chk++;
      if (int'(dac) !== ed) begin
        n_fail++;
        $display("FAIL %s dac cyc %0d got %0d exp %0d",
                 nm, k, dac, ed);
      end
      er = idx_of(k >= 1 ? q_pnt[k-1] : of);
      n_chk++;
      if (int'(rpnt) !== er) begin
        n_fail++;
        $display("FAIL %s rpnt cyc %0d got %0d exp %0d",
                 nm, k, rpnt, er);
      end
      trig = q_busy[k] ? 1'($urandom % 2) : 1'b0;
      tick();
    end
    trig = 0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_chk++;
    if ({dac, rpnt, busy, td} !== '0) begin
      n_fail++;
      $display("FAIL reset outputs got %h exp 0",
               {dac, rpnt, busy, td});
    end
    rst = 0;
    tick();
    n_chk++;
    if (busy !== 1'b0 || td !== 1'b0) begin
      n_fail++;
      $display("FAIL reset idle busy %0b td %0b exp 0 0",
               busy, td);
    end
  endtask

  task automatic test_sweep();
    int nb, nt;
    for (int i = 0; i < 1024; i++) wr(i, 8 * i);
    size = 30'h3FF_FFFF;
    step = 30'h1_0000;
    ofs = 0;
    ncyc = 2;
    rnum = 0;
    interp = 0;
    amp = 14'h2000;
    dc = 0;
    run_burst("sweep", nb, nt);
    n_chk++;
    if (nb != 2048) begin
      n_fail++;
      $display("FAIL sweep busy clocks got %0d exp 2048", nb);
    end
    n_chk++;
    if (nt != 3) begin
      n_fail++;
      $display("FAIL sweep pulses got %0d exp 3", nt);
    end
    n_chk++;
    if (q_obs[6] != 0 || q_obs[7] != 8 || q_obs[8] != 16) begin
      n_fail++;
      $display("FAIL sweep ramp got %0d %0d %0d exp 0 8 16",
               q_obs[6], q_obs[7], q_obs[8]);
    end
  endtask

  task automatic test_interp();
    int nb, nt;
    int ex [5];
    ex = '{0, 250, 500, 750, 1000};
    wr(0, 0);
    wr(1, 1000);
    size = 30'h1_FFFF;
    step = 30'h4000;
    ofs = 0;
    ncyc = 1;
    rnum = 0;
    interp = 1;
    run_burst("interp", nb, nt);
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (q_obs[6+i] != ex[i]) begin
        n_fail++;
        $display("FAIL interp step %0d got %0d exp %0d",
                 i, q_obs[6+i], ex[i]);
      end
    end
  endtask

  task automatic test_gain();
    int e;
    interp = 0;
    ofs = 0;
    size = 30'h1_FFFF;
    amp = 14'h3FFF;
    dc = 14'h1000;
    wr(0, 'h1FFF);
    repeat (8) tick();
    n_chk++;
    if (dac !== 14'h1FFF) begin
      n_fail++;
      $display("FAIL gain pos sat got %h exp 1fff", dac);
    end
    dc = 14'h3000;
    wr(0, 'h2000);
    repeat (8) tick();
    n_chk++;
    if (dac !== 14'h2000) begin
      n_fail++;
      $display("FAIL gain neg sat got %h exp 2000", dac);
    end
    for (int r = 0; r < 6; r++) begin
      wr(0, int'($urandom));
      amp = 14'($urandom);
      dc = 14'($urandom);
      repeat (8) tick();
      e = model_out(0);
      n_chk++;
      if (int'(dac) !== e) begin
        n_fail++;
        $display("FAIL gain rand %0d got %0d exp %0d",
                 r, dac, e);
      end
    end
    zero = 1;
    tick();
    n_chk++;
    if (dac !== 14'h0) begin
      n_fail++;
      $display("FAIL zero got %h exp 0", dac);
    end
    zero = 0;
    tick();
    n_chk++;
    if (int'(dac) !== e) begin
      n_fail++;
      $display("FAIL unzero got %0d exp %0d", dac, e);
    end
  endtask

  task automatic test_bursts();
    int nb, nt;
    for (int i = 0; i < 16; i++) wr(i, int'($urandom));
    size = 30'hF_FFFF;
    step = 30'($urandom_range('h8000, 'h20000));
    ofs = 0;
    wrap = 1;
    interp = 1;
    amp = 14'h2000;
    dc = 0;
    ncyc = 1;
    rnum = 2;
    rdly = 10;
    run_burst("bursts", nb, nt);
    n_chk++;
    if (nt != 6) begin
      n_fail++;
      $display("FAIL bursts pulses got %0d exp 6", nt);
    end
  endtask

  task automatic test_random();
    int nb, nt, si;
    for (int r = 0; r < 6; r++) begin
      si = int'($urandom_range(4, 40));
      for (int i = 0; i <= si; i++) wr(i, int'($urandom));
      size = 30'((si << 16) | int'($urandom_range(0, 65535)));
      step = 30'($urandom_range(int'(size) / 24 + 1,
                                int'(size) + 1));
      ofs = 30'($urandom_range(0, int'(size)));
      wrap = 1'($urandom % 2);
      interp = 1'($urandom % 2);
      amp = 14'($urandom);
      dc = 14'($urandom);
      ncyc = 32'($urandom_range(1, 3));
      rnum = 16'($urandom_range(0, 2));
      rdly = 32'($urandom_range(0, 5));
      run_burst($sformatf("rand%0d", r), nb, nt);
    end
  endtask

  task automatic test_set_rst();
    size = 30'h1F_FFFF;
    step = 30'h1_8000;
    ofs = 30'h5_0000;
    ncyc = 0;
    rnum = 0;
    repeat (8) tick();
    trig = 1;
    tick();
    trig = 0;
    repeat (20) tick();
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL setrst running got %0b exp 1", busy);
    end
    srst = 1;
    tick();
    srst = 0;
    n_chk++;
    if (busy !== 1'b0 || td !== 1'b0) begin
      n_fail++;
      $display("FAIL setrst stop busy %0b td %0b exp 0 0",
               busy, td);
    end
    tick();
    n_chk++;
    if (rpnt !== 14'd5) begin
      n_fail++;
      $display("FAIL setrst pnt got %0d exp 5", rpnt);
    end
    srst = 1;
    trig = 1;
    tick();
    srst = 0;
    trig = 0;
    n_chk++;
    if (busy !== 1'b0 || td !== 1'b0) begin
      n_fail++;
      $display("FAIL setrst trig busy %0b td %0b exp 0 0",
               busy, td);
    end
    repeat (3) tick();
    n_chk++;
    if (busy !== 1'b0 || rpnt !== 14'd5) begin
      n_fail++;
      $display("FAIL setrst idle busy %0b rpnt %0d exp 0 5",
               busy, rpnt);
    end
  endtask

  task automatic test_async_rst();
    size = 30'h3FF_FFFF;
    step = 30'h1_0000;
    ofs = 0;
    ncyc = 0;
    interp = 0;
    amp = 14'h2000;
    dc = 0;
    for (int i = 0; i < 64; i++) wr(i, 8 * i + 1);
    repeat (8) tick();
    trig = 1;
    tick();
    trig = 0;
    repeat (30) tick();
    n_chk++;
    if (busy !== 1'b1 || dac === 14'h0) begin
      n_fail++;
      $display("FAIL arst pre busy %0b dac %0d exp 1 nonzero",
               busy, dac);
    end
    #2;
    rst = 1;
    #1;
    n_chk++;
    if (dac !== 14'h0 || busy !== 1'b0 || td !== 1'b0) begin
      n_fail++;
      $display("FAIL arst dac %0d busy %0b td %0b exp 0 0 0",
               dac, busy, td);
    end
    tick();
    rst = 0;
    tick();
  endtask

  initial begin
    bif.buf_we_i = 1'b0;
    bif.buf_addr_i = '0;
    bif.buf_wdata_i = '0;
    for (int i = 0; i < 16384; i++) mem_m[i] = 0;
    test_reset();
    test_sweep();
    test_interp();
    test_gain();
    test_bursts();
    test_random();
    test_set_rst();
    test_async_rst();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
